// File: rtl/flash_cmd_pkg.sv
// Shared types and constants for the flash command sequencer.
package flash_cmd_pkg;

  // Host-visible command encoding
  typedef enum logic [1:0] {
    OpProgram     = 2'd0,
    OpSectorErase = 2'd1,
    OpChipErase   = 2'd2,
    OpResetCmd    = 2'd3
  } cmd_op_e;

  // JEDEC command bytes (driven as {c, c} across both lanes)
  localparam logic [7:0] CmdUnlock1 = 8'hAA;
  localparam logic [7:0] CmdUnlock2 = 8'h55;
  localparam logic [7:0] CmdProgram = 8'hA0;
  localparam logic [7:0] CmdErase   = 8'h80;
  localparam logic [7:0] CmdSector  = 8'h30;
  localparam logic [7:0] CmdChip    = 8'h10;
  localparam logic [7:0] CmdReset   = 8'hF0;

  // Unlock word addresses
  localparam logic [11:0] AddrUnlock1 = 12'h555;
  localparam logic [11:0] AddrUnlock2 = 12'h2AA;

  typedef enum logic [1:0] {
    ASelZero,
    ASelUnlock1,
    ASelUnlock2,
    ASelCmd
  } addr_sel_e;

  typedef struct packed {
    addr_sel_e  addr_sel;
    logic [7:0] cmd_byte;
    logic       last;
  } seq_entry_t;

  typedef enum logic [3:0] {
    StIdle,
    StWaitGnt,
    StWrSetup,
    StWrStrobe,
    StWrHold,
    StPollRd,
    StPollGap,
    StDone,
    StFail
  } state_e;

endpackage

// File: rtl/flash_cmd_sequencer_if.sv
// Command-side handshake between the session register front end and the sequencer.
interface flash_cmd_sequencer_if #(
  parameter int unsigned ADDR_W = 19
) ();
  logic              CMD_VALID;
  logic              CMD_READY;
  logic [1:0]        CMD_OP;
  logic [ADDR_W-1:0] CMD_ADDR;
  logic [15:0]       CMD_DATA;
  logic              BUSY;
  logic              DONE;
  logic              ERR;

  modport master (
    output CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA,
    input  CMD_READY, BUSY, DONE, ERR
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA,
    output CMD_READY, BUSY, DONE, ERR
  );
endinterface

// File: rtl/flash_seq_rom.sv
// JEDEC write-cycle table: (op, step) -> address select, command byte, last flag.
module flash_seq_rom import flash_cmd_pkg::*; (
  input  cmd_op_e    op_i,
  input  logic [2:0] step_i,
  output seq_entry_t entry_o
);

  // Table lookup; out-of-range steps read as a terminal entry
  always_comb begin
    entry_o = seq_entry_t'{addr_sel: ASelZero, cmd_byte: CmdReset, last: 1'b1};
    case (op_i)
      OpProgram: begin
        case (step_i)
          3'd0: entry_o = seq_entry_t'{ASelUnlock1, CmdUnlock1, 1'b0};
          3'd1: entry_o = seq_entry_t'{ASelUnlock2, CmdUnlock2, 1'b0};
          3'd2: entry_o = seq_entry_t'{ASelUnlock1, CmdProgram, 1'b0};
          3'd3: entry_o = seq_entry_t'{ASelCmd, 8'h00, 1'b1};
          default: ;
        endcase
      end
      OpSectorErase, OpChipErase: begin
        case (step_i)
          3'd0: entry_o = seq_entry_t'{ASelUnlock1, CmdUnlock1, 1'b0};
          3'd1: entry_o = seq_entry_t'{ASelUnlock2, CmdUnlock2, 1'b0};
          3'd2: entry_o = seq_entry_t'{ASelUnlock1, CmdErase, 1'b0};
          3'd3: entry_o = seq_entry_t'{ASelUnlock1, CmdUnlock1, 1'b0};
          3'd4: entry_o = seq_entry_t'{ASelUnlock2, CmdUnlock2, 1'b0};
          3'd5: entry_o = (op_i == OpSectorErase) ?
                          seq_entry_t'{ASelCmd, CmdSector, 1'b1} :
                          seq_entry_t'{ASelUnlock1, CmdChip, 1'b1};
          default: ;
        endcase
      end
      OpResetCmd: begin
        if (step_i == 3'd0) entry_o = seq_entry_t'{ASelZero, CmdReset, 1'b1};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/flash_cmd_sequencer.sv
// Timed JEDEC command sequencer with DQ6/DQ5 toggle polling for the paired Kickstart flashes.
module flash_cmd_sequencer import flash_cmd_pkg::*; #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned WE_LOW = 2,
  parameter int unsigned RD_LOW = 2,
  parameter int unsigned TO_W   = 28
) (
  input  logic                 MB_CLK,
  input  logic                 RESET,
  flash_cmd_sequencer_if.slave cmd,
  output logic                 BUS_REQ,
  input  logic                 BUS_GNT,
  output logic [ADDR_W-1:0]    FLASH_A,
  output logic [15:0]          FLASH_DQ_OUT,
  output logic                 FLASH_DQ_OE,
  input  logic [15:0]          FLASH_DQ_IN,
  output logic [1:0]           FLASH_WE_N,
  output logic [1:0]           FLASH_OE_N
);

  localparam int unsigned CntMax = (WE_LOW > RD_LOW) ? WE_LOW : RD_LOW;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_e            state_q;
  cmd_op_e           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
  logic [2:0]        step_q;
  logic              last_q;
  logic [CntW-1:0]   cnt_q;
  logic [TO_W-1:0]   to_q;
  logic [1:0]        prev_q;      // {DQ14, DQ6} from the previous poll read
  logic              have_prev_q;
  logic              retry_q;     // DQ5 seen on a toggling lane; one confirming read left
  logic              busy_q, done_q, err_q, bus_req_q, dq_oe_q;
  logic [ADDR_W-1:0] fa_q;
  logic [15:0]       dq_q;
  logic [1:0]        we_n_q, oe_n_q;

  seq_entry_t        rom_entry;
  logic [2:0]        rom_step;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              tog_hi, tog_lo, toggling, fault;
  logic              sample_now, gnt_lost, to_expired, poll_fail, fail_now;
  logic              unused_dq;

  // In WR_HOLD the table is looked ahead so the next setup loads on the same edge
  assign rom_step = (state_q == StWrHold) ? step_q + 3'd1 : step_q;

  flash_seq_rom u_rom (
    .op_i   (op_q),
    .step_i (rom_step),
    .entry_o(rom_entry)
  );

  // Address and data for the selected write cycle
  always_comb begin
    rom_addr = '0;
    unique case (rom_entry.addr_sel)
      ASelZero:    rom_addr = '0;
      ASelUnlock1: rom_addr = ADDR_W'(AddrUnlock1);
      ASelUnlock2: rom_addr = ADDR_W'(AddrUnlock2);
      ASelCmd:     rom_addr = addr_q;
    endcase
    rom_data = {rom_entry.cmd_byte, rom_entry.cmd_byte};
    if (op_q == OpProgram && rom_entry.addr_sel == ASelCmd) rom_data = data_q;
  end

  // Toggle / fault detection and failure conditions
  always_comb begin
    tog_hi     = FLASH_DQ_IN[14] ^ prev_q[1];
    tog_lo     = FLASH_DQ_IN[6] ^ prev_q[0];
    toggling   = tog_hi | tog_lo;
    fault      = (tog_hi & FLASH_DQ_IN[13]) | (tog_lo & FLASH_DQ_IN[5]);
    sample_now = (state_q == StPollRd) && (cnt_q == '0);
    gnt_lost   = bus_req_q && !BUS_GNT &&
                 (state_q inside {StWrSetup, StWrStrobe, StWrHold, StPollRd, StPollGap});
    to_expired = (state_q inside {StPollRd, StPollGap}) && (&to_q);
    poll_fail  = sample_now && have_prev_q && toggling && retry_q;
    fail_now   = gnt_lost | to_expired | poll_fail;
  end

  assign unused_dq = ^{FLASH_DQ_IN[15], FLASH_DQ_IN[12:7], FLASH_DQ_IN[4:0]};

  // Sequencer FSM with registered outputs; failure conditions override the per-state action
  always_ff @(posedge MB_CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      op_q        <= OpProgram;
      addr_q      <= '0;
      data_q      <= '0;
      step_q      <= '0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      to_q        <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      retry_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      dq_oe_q     <= 1'b0;
      fa_q        <= '0;
      dq_q        <= '0;
      we_n_q      <= 2'b11;
      oe_n_q      <= 2'b11;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd.CMD_VALID) begin
            op_q      <= cmd_op_e'(cmd.CMD_OP);
            addr_q    <= cmd.CMD_ADDR;
            data_q    <= cmd.CMD_DATA;
            step_q    <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            bus_req_q <= 1'b1;
            state_q   <= StWaitGnt;
          end
        end
        StWaitGnt: begin
          if (BUS_GNT) begin
            fa_q    <= rom_addr;
            dq_q    <= rom_data;
            dq_oe_q <= 1'b1;
            last_q  <= rom_entry.last;
            state_q <= StWrSetup;
          end
        end
        StWrSetup: begin
          we_n_q  <= 2'b00;
          cnt_q   <= CntW'(WE_LOW - 1);
          state_q <= StWrStrobe;
        end
        StWrStrobe: begin
          if (cnt_q == '0) begin
            we_n_q  <= 2'b11;
            state_q <= StWrHold;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWrHold: begin
          if (!last_q) begin
            step_q  <= step_q + 3'd1;
            fa_q    <= rom_addr;
            dq_q    <= rom_data;
            last_q  <= rom_entry.last;
            state_q <= StWrSetup;
          end else if (op_q == OpResetCmd) begin
            dq_oe_q   <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            bus_req_q <= 1'b0;
            state_q   <= StDone;
          end else begin
            dq_oe_q     <= 1'b0;
            oe_n_q      <= 2'b00;
            cnt_q       <= CntW'(RD_LOW - 1);
            to_q        <= '0;
            have_prev_q <= 1'b0;
            retry_q     <= 1'b0;
            state_q     <= StPollRd;
          end
        end
        StPollRd: begin
          to_q <= to_q + 1'b1;
          if (!sample_now) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            oe_n_q      <= 2'b11;
            prev_q      <= {FLASH_DQ_IN[14], FLASH_DQ_IN[6]};
            have_prev_q <= 1'b1;
            if (have_prev_q && !toggling) begin
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              bus_req_q <= 1'b0;
              state_q   <= StDone;
            end else begin
              retry_q <= retry_q | (have_prev_q & fault);
              state_q <= StPollGap;
            end
          end
        end
        StPollGap: begin
          to_q    <= to_q + 1'b1;
          oe_n_q  <= 2'b00;
          cnt_q   <= CntW'(RD_LOW - 1);
          state_q <= StPollRd;
        end
        StDone:  state_q <= StIdle;
        StFail:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if (fail_now) begin
        we_n_q    <= 2'b11;
        oe_n_q    <= 2'b11;
        dq_oe_q   <= 1'b0;
        done_q    <= 1'b0;
        busy_q    <= 1'b0;
        bus_req_q <= 1'b0;
        err_q     <= 1'b1;
        state_q   <= StFail;
      end
    end
  end

  assign cmd.CMD_READY = (state_q == StIdle);
  assign cmd.BUSY      = busy_q;
  assign cmd.DONE      = done_q;
  assign cmd.ERR       = err_q;
  assign BUS_REQ       = bus_req_q;
  assign FLASH_A       = fa_q;
  assign FLASH_DQ_OUT  = dq_q;
  assign FLASH_DQ_OE   = dq_oe_q;
  assign FLASH_WE_N    = we_n_q;
  assign FLASH_OE_N    = oe_n_q;

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Directed bench: command table with a toggle-bit flash model, plus reset and grant-loss cases.
module tb_flash_cmd_sequencer;

  localparam int unsigned AW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          bus_req, bus_gnt;
  logic [AW-1:0] fa;
  logic [15:0]   dq_out, dq_in;
  logic          dq_oe;
  logic [1:0]    we_n, oe_n;

  always #5 clk = ~clk;

  flash_cmd_sequencer_if #(.ADDR_W(AW)) cmd_if ();

  flash_cmd_sequencer #(
    .ADDR_W(AW),
    .WE_LOW(2),
    .RD_LOW(2),
    .TO_W  (8)
  ) dut (
    .MB_CLK      (clk),
    .RESET       (rst),
    .cmd         (cmd_if),
    .BUS_REQ     (bus_req),
    .BUS_GNT     (bus_gnt),
    .FLASH_A     (fa),
    .FLASH_DQ_OUT(dq_out),
    .FLASH_DQ_OE (dq_oe),
    .FLASH_DQ_IN (dq_in),
    .FLASH_WE_N  (we_n),
    .FLASH_OE_N  (oe_n)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Flash model: the chosen lane's DQ6 toggles for the first n_tog reads, then holds
  int rd_total = 0;
  int rd_base  = 0;
  int n_tog    = 1;
  bit tog_upper = 1'b0;
  bit dq5       = 1'b0;

  always @(posedge oe_n[0]) rd_total++;

  always_comb begin
    int r;
    int t;
    bit v;
    r = rd_total - rd_base;
    t = n_tog - 1;
    v = (r < n_tog) ? r[0] : t[0];
    dq_in = 16'h0000;
    if (tog_upper) begin
      dq_in[14] = v;
      dq_in[13] = dq5;
    end else begin
      dq_in[6] = v;
      dq_in[5] = dq5;
    end
  end

  // Write-cycle trace: address/data/OE captured at strobe start, strobe length in cycles
  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  wr_t        trace[$];
  int         trace_len[$];
  logic       trace_oe[$];
  logic [1:0] trace_we[$];
  int         low_cnt = 0;
  wr_t        cur;
  logic       cur_oe;
  logic [1:0] cur_we;
  int         done_total = 0;

  always @(negedge clk) begin
    if (we_n != 2'b11) begin
      if (low_cnt == 0) begin
        cur    = '{a: fa, d: dq_out};
        cur_oe = dq_oe;
        cur_we = we_n;
      end
      low_cnt++;
    end else if (low_cnt != 0) begin
      trace.push_back(cur);
      trace_len.push_back(low_cnt);
      trace_oe.push_back(cur_oe);
      trace_we.push_back(cur_we);
      low_cnt = 0;
    end
  end

  always @(negedge clk) if (cmd_if.DONE === 1'b1) done_total++;

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [15:0]   data;
    int            gnt_delay;
    int            n_tog;
    bit            tog_upper;
    bit            dq5;
    int            wr_first;
    int            wr_cnt;
    bit            exp_done;
    bit            exp_err;
    int            exp_reads;  // -1: not checked
    bit            poke;       // assert CMD_VALID again while busy
  } vec_t;

  vec_t vecs[6];
  wr_t  exp_wr[25];

  task automatic accept(input logic [1:0] op, input logic [AW-1:0] addr, input logic [15:0] data);
    cmd_if.CMD_VALID = 1'b1;
    cmd_if.CMD_OP    = op;
    cmd_if.CMD_ADDR  = addr;
    cmd_if.CMD_DATA  = data;
    @(negedge clk);
    cmd_if.CMD_VALID = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  tb0;
    int  db0;
    int  cyc;
    bit  finished;
    n_tog     = v.n_tog;
    tog_upper = v.tog_upper;
    dq5       = v.dq5;
    rd_base   = rd_total;
    tb0       = trace.size();
    db0       = done_total;
    bus_gnt   = (v.gnt_delay == 0);
    check($sformatf("v%0d ready_before", idx), cmd_if.CMD_READY, 1);
    accept(v.op, v.addr, v.data);
    check($sformatf("v%0d bus_req_after_accept", idx), bus_req, 1);
    check($sformatf("v%0d busy_after_accept", idx), cmd_if.BUSY, 1);
    check($sformatf("v%0d err_cleared_at_accept", idx), cmd_if.ERR, 0);
    check($sformatf("v%0d ready_low_busy", idx), cmd_if.CMD_READY, 0);
    if (v.gnt_delay > 0) begin
      repeat (v.gnt_delay) @(negedge clk);
      check($sformatf("v%0d no_strobe_without_gnt", idx), {we_n, dq_oe}, {2'b11, 1'b0});
      bus_gnt = 1'b1;
    end
    if (v.poke) begin
      cmd_if.CMD_VALID = 1'b1;
      cmd_if.CMD_OP    = 2'd3;
      repeat (3) @(negedge clk);
      cmd_if.CMD_VALID = 1'b0;
    end
    finished = 1'b0;
    for (cyc = 0; cyc < 2000 && !finished; cyc++) begin
      @(negedge clk);
      if (cmd_if.DONE === 1'b1 || cmd_if.ERR === 1'b1) finished = 1'b1;
    end
    check($sformatf("v%0d completed_in_budget", idx), finished, 1);
    repeat (3) @(negedge clk);
    check($sformatf("v%0d ready_after", idx), cmd_if.CMD_READY, 1);
    check($sformatf("v%0d bus_req_dropped", idx), bus_req, 0);
    check($sformatf("v%0d busy_dropped", idx), cmd_if.BUSY, 0);
    check($sformatf("v%0d err", idx), cmd_if.ERR, v.exp_err);
    check($sformatf("v%0d done_pulses", idx), done_total - db0, v.exp_done ? 1 : 0);
    check($sformatf("v%0d write_count", idx), trace.size() - tb0, v.wr_cnt);
    for (int k = 0; k < v.wr_cnt; k++) begin
      if (tb0 + k < trace.size()) begin
        check($sformatf("v%0d wr%0d addr", idx, k), trace[tb0+k].a, exp_wr[v.wr_first+k].a);
        check($sformatf("v%0d wr%0d data", idx, k), trace[tb0+k].d, exp_wr[v.wr_first+k].d);
        check($sformatf("v%0d wr%0d we_low_len", idx, k), trace_len[tb0+k], 2);
        check($sformatf("v%0d wr%0d both_lanes", idx, k), trace_we[tb0+k], 2'b00);
        check($sformatf("v%0d wr%0d dq_oe", idx, k), trace_oe[tb0+k], 1);
      end
    end
    if (v.exp_reads >= 0)
      check($sformatf("v%0d poll_reads", idx), rd_total - rd_base, v.exp_reads);
  endtask

  task automatic wait_strobe(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (we_n == 2'b00) seen = 1'b1;
    end
    check(name, seen, 1);
  endtask

  initial begin
    exp_wr[0]  = '{19'h00555, 16'hAAAA};
    exp_wr[1]  = '{19'h002AA, 16'h5555};
    exp_wr[2]  = '{19'h00555, 16'hA0A0};
    exp_wr[3]  = '{19'h12345, 16'hBEEF};
    exp_wr[4]  = '{19'h00555, 16'hAAAA};
    exp_wr[5]  = '{19'h002AA, 16'h5555};
    exp_wr[6]  = '{19'h00555, 16'h8080};
    exp_wr[7]  = '{19'h00555, 16'hAAAA};
    exp_wr[8]  = '{19'h002AA, 16'h5555};
    exp_wr[9]  = '{19'h40000, 16'h3030};
    exp_wr[10] = '{19'h00555, 16'hAAAA};
    exp_wr[11] = '{19'h002AA, 16'h5555};
    exp_wr[12] = '{19'h00555, 16'h8080};
    exp_wr[13] = '{19'h00555, 16'hAAAA};
    exp_wr[14] = '{19'h002AA, 16'h5555};
    exp_wr[15] = '{19'h00555, 16'h1010};
    exp_wr[16] = '{19'h00555, 16'hAAAA};
    exp_wr[17] = '{19'h002AA, 16'h5555};
    exp_wr[18] = '{19'h00555, 16'hA0A0};
    exp_wr[19] = '{19'h00ABC, 16'h1234};
    exp_wr[20] = '{19'h00000, 16'hF0F0};
    exp_wr[21] = '{19'h00555, 16'hAAAA};
    exp_wr[22] = '{19'h002AA, 16'h5555};
    exp_wr[23] = '{19'h00555, 16'hA0A0};
    exp_wr[24] = '{19'h7FFFF, 16'h0001};

    //         op    addr        data      gdly ntog     up  dq5 first cnt done err reads poke
    vecs[0] = '{2'd0, 19'h12345, 16'hBEEF, 0, 3,       0,  0,  0,    4,  1,   0,  4,    0};
    vecs[1] = '{2'd1, 19'h40000, 16'h0000, 3, 2,       0,  0,  4,    6,  1,   0,  3,    0};
    vecs[2] = '{2'd2, 19'h00000, 16'h0000, 0, 1 << 30, 1,  1,  10,   6,  0,   1,  3,    0};
    vecs[3] = '{2'd0, 19'h00ABC, 16'h1234, 0, 1 << 30, 0,  0,  16,   4,  0,   1,  -1,   0};
    vecs[4] = '{2'd3, 19'h12345, 16'h5A5A, 0, 1,       0,  0,  20,   1,  1,   0,  0,    0};
    vecs[5] = '{2'd0, 19'h7FFFF, 16'h0001, 0, 1,       0,  0,  21,   4,  1,   0,  2,    1};

    rst              = 1'b1;
    bus_gnt          = 1'b0;
    cmd_if.CMD_VALID = 1'b0;
    cmd_if.CMD_OP    = 2'd0;
    cmd_if.CMD_ADDR  = '0;
    cmd_if.CMD_DATA  = '0;
    repeat (3) @(negedge clk);
    check("rst ready", cmd_if.CMD_READY, 1);
    check("rst busy", cmd_if.BUSY, 0);
    check("rst done", cmd_if.DONE, 0);
    check("rst err", cmd_if.ERR, 0);
    check("rst bus_req", bus_req, 0);
    check("rst flash_a", fa, 0);
    check("rst dq_out", dq_out, 0);
    check("rst dq_oe", dq_oe, 0);
    check("rst we_n", we_n, 2'b11);
    check("rst oe_n", oe_n, 2'b11);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Synchronous reset in the middle of a write strobe
    bus_gnt = 1'b1;
    accept(2'd0, 19'h01234, 16'hCAFE);
    wait_strobe("midrst strobe_seen");
    rst = 1'b1;
    @(negedge clk);
    check("midrst we_n", we_n, 2'b11);
    check("midrst dq_oe", dq_oe, 0);
    check("midrst bus_req", bus_req, 0);
    check("midrst ready", cmd_if.CMD_READY, 1);
    check("midrst busy", cmd_if.BUSY, 0);
    rst = 1'b0;
    @(negedge clk);

    // Grant withdrawn during a strobe: strobes released and ERR on the sampling edge
    accept(2'd1, 19'h20000, 16'h0000);
    wait_strobe("gntdrop strobe_seen");
    bus_gnt = 1'b0;
    @(negedge clk);
    check("gntdrop we_n", we_n, 2'b11);
    check("gntdrop dq_oe", dq_oe, 0);
    check("gntdrop bus_req", bus_req, 0);
    check("gntdrop err", cmd_if.ERR, 1);
    @(negedge clk);
    check("gntdrop ready", cmd_if.CMD_READY, 1);
    bus_gnt = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/flash_cmd_sequencer.md
# flash_cmd_sequencer

Sequences JEDEC command cycles (unlock, program, sector/chip erase, reset) into the paired 8-bit Kickstart flash devices on the relocator, then polls DQ6 toggle / DQ5 status until completion, timeout or device error. It owns the flash bus during an operation through a request/grant pair with the CPU-side decode path. It is driven by a programming-session register front end, and replaces ad-hoc CPU-issued unlock writes with a deterministic, timed state machine.

## Interface
- ADDR_W, 19: flash word-address width (512K words, 1 MB).
- WE_LOW, 2: MB_CLK cycles FLASH_WE_N held low per write cycle (≥1).
- RD_LOW, 2: MB_CLK cycles FLASH_OE_N held low per poll read (≥1); data sampled on the last low cycle.
- TO_W, 28: poll timeout counter width; timeout when counter reaches all-ones.
- MB_CLK  in  1  7 MHz motherboard clock; sole clock.
- RESET  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  high only in IDLE.
- CMD_OP  in  2  0 PROGRAM, 1 SECTOR_ERASE, 2 CHIP_ERASE, 3 RESET_CMD.
- CMD_ADDR  in  ADDR_W  target word / sector address.
- CMD_DATA  in  16  program data (PROGRAM only).
- BUSY  out  1  high from accept until DONE/ERR.
- DONE  out  1  one-cycle pulse on successful completion.
- ERR  out  1  sticky; set on DQ5 fault or timeout, cleared by next accepted command.
- BUS_REQ  out  1  flash bus request.
- BUS_GNT  in  1  flash bus grant; must stay high while BUS_REQ high.
- FLASH_A  out  ADDR_W  flash word address.
- FLASH_DQ_OUT  out  16  write data, both lanes.
- FLASH_DQ_OE  out  1  drive FLASH_DQ_OUT onto bus.
- FLASH_DQ_IN  in  16  read data.
- FLASH_WE_N  out  2  per-lane write strobe {upper, lower}.
- FLASH_OE_N  out  2  per-lane output enable.

## Operation
- Reset values: CMD_READY 1, BUSY 0, DONE 0, ERR 0, BUS_REQ 0, FLASH_A 0, FLASH_DQ_OUT 0, FLASH_DQ_OE 0, FLASH_WE_N 2'b11, FLASH_OE_N 2'b11.
- Accept on CMD_VALID & CMD_READY; latch OP/ADDR/DATA; clear ERR; raise BUS_REQ; state WAIT_GNT.
- States: IDLE, WAIT_GNT, WR_SETUP, WR_STROBE, WR_HOLD, POLL_RD, POLL_GAP, DONE, FAIL.
- Command byte c is driven on both lanes as {c,c}; unlock addresses are word addresses 0x555 / 0x2AA.
- PROGRAM: AA@555, 55@2AA, A0@555, CMD_DATA@CMD_ADDR (4 cycles).
- SECTOR_ERASE: AA@555, 55@2AA, 80@555, AA@555, 55@2AA, 30@CMD_ADDR (6).
- CHIP_ERASE: as sector erase, last cycle 10@555 (6).
- RESET_CMD: F0@000 (1); no polling, DONE directly after WR_HOLD.
- Write cycle: WR_SETUP 1 cycle (A, DQ, DQ_OE valid, WE_N high); WR_STROBE WE_LOW cycles, WE_N 2'b00; WR_HOLD 1 cycle, WE_N high, A/DQ stable. Step index 3-bit, advances in WR_HOLD.
- Poll: DQ_OE 0; POLL_RD asserts OE_N 2'b00 RD_LOW cycles, samples FLASH_DQ_IN on last; POLL_GAP 1 cycle OE_N high. Compare bits 14 and 6 against previous sample.
- Neither lane toggled (second and later samples) -> DONE.
- Toggling lane with its DQ5 (bit 13 / 5) set: one more read; still toggling -> FAIL, else DONE.
- Timeout counter cleared on entering poll, increments every cycle while polling; all-ones -> FAIL.
- DONE: DONE pulse 1 cycle, BUS_REQ dropped, -> IDLE. FAIL: ERR set, BUS_REQ dropped, -> IDLE. Host recovers with RESET_CMD.
- BUS_GNT falling while BUS_REQ high is a protocol violation: -> FAIL, strobes released same cycle.
- RESET mid-operation: all outputs to reset values next edge regardless of state.

## Timing
- Accept -> BUS_REQ: next cycle. BUS_GNT high -> first WR_SETUP: next cycle.
- Each write cycle WE_LOW+2 clocks; PROGRAM write phase 4*(WE_LOW+2) = 16 at defaults.
- Each poll read RD_LOW+1 clocks; minimum two reads before DONE.
- CMD_VALID while busy ignored (CMD_READY low); no queueing.

## Structure
- Package flash_cmd_pkg: CMD_OP encoding, JEDEC command bytes (AA, 55, A0, 80, 30, 10, F0), unlock addresses, state enum.
- Sub-module flash_seq_rom: combinational (op, step) -> {addr_sel, byte, last}; FSM instantiates one.

## Test plan
- PROGRAM addr 0x12345 data 0xBEEF, GNT immediate, model toggles DQ6 3 reads then stable -> write trace 555/AA,2AA/55,555/A0,12345/BEEF, DONE after fourth read, ERR 0.
- SECTOR_ERASE 0x40000 -> six cycles ending 30 on both lanes at 0x40000, WE_N low exactly WE_LOW clocks each.
- CHIP_ERASE, model toggles with DQ5=1 on upper lane -> ERR 1, no DONE, BUS_REQ low, CMD_READY 1.
- PROGRAM, model toggles forever, TO_W=8 -> FAIL once counter reaches 255, ERR 1.
- RESET_CMD after failure -> single F0@000 cycle, DONE pulse, ERR cleared at accept.
- RESET asserted during WR_STROBE -> next edge WE_N 2'b11, DQ_OE 0, BUS_REQ 0, CMD_READY 1.
